// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like request port between the inst and data requesters; data wins
// unless inst has been starved, and an in-order source FIFO steers each response back.
module sram_port_arbiter #(
  parameter int OUTST_DEPTH  = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  // inst requester
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  // data requester
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  // downstream port
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic        err_orphan
);

  localparam int AW = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(OUTST_DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD_I = 2'd1,
    ST_HOLD_D = 2'd2
  } state_t;

  state_t          r_state;
  logic [SW-1:0]   r_starve;
  logic [AW:0]     r_count;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic            r_src [OUTST_DEPTH];
  logic            r_orphan;

  logic w_full;
  logic w_empty;
  logic w_inst_urgent;
  logic w_grant_d;
  logic w_grant_i;
  logic w_sel_i;
  logic w_sel_d;
  logic w_push;
  logic w_pop;
  logic w_head;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);

  // New grants only from IDLE and only with a free FIFO slot; a HOLD always finishes.
  assign w_inst_urgent = i_req && (r_starve == LIMIT_C);
  assign w_grant_d = !rst && (r_state == ST_IDLE) && !w_full && d_req && !w_inst_urgent;
  assign w_grant_i = !rst && (r_state == ST_IDLE) && !w_full && i_req && !w_grant_d;

  assign w_sel_i = w_grant_i || (r_state == ST_HOLD_I);
  assign w_sel_d = w_grant_d || (r_state == ST_HOLD_D);

  assign m_req   = w_sel_i || w_sel_d;
  assign m_wr    = w_sel_i ? i_wr    : d_wr;
  assign m_size  = w_sel_i ? i_size  : d_size;
  assign m_addr  = w_sel_i ? i_addr  : d_addr;
  assign m_wdata = w_sel_i ? i_wdata : d_wdata;
  assign m_wstrb = w_sel_i ? i_wstrb : d_wstrb;

  assign i_addr_ok = m_addr_ok && w_sel_i;
  assign d_addr_ok = m_addr_ok && w_sel_d;

  assign w_push = m_addr_ok && m_req;
  assign w_pop  = m_data_ok && !w_empty;
  assign w_head = r_src[r_rptr];

  assign i_data_ok = w_pop && !w_head;
  assign d_data_ok = w_pop && w_head;
  assign i_rdata   = i_data_ok ? m_rdata : '0;
  assign d_rdata   = d_data_ok ? m_rdata : '0;

  assign err_orphan = r_orphan;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (m_req && !m_addr_ok) begin
      r_state <= w_sel_i ? ST_HOLD_I : ST_HOLD_D;
    end else begin
      r_state <= ST_IDLE;
    end
  end

  // Counts cycles inst is left waiting behind a data grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (!i_req || i_addr_ok) begin
      r_starve <= '0;
    end else if (d_req && w_sel_d && (r_starve != LIMIT_C)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int k = 0; k < OUTST_DEPTH; k++) r_src[k] <= 1'b0;
    end else begin
      if (w_push) begin
        r_src[r_wptr] <= w_sel_d;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_orphan <= 1'b0;
    end else if (m_data_ok && w_empty) begin
      r_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with hand-computed expectations.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_wr, d_req, d_wr;
  logic [1:0]  i_size, d_size;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
  logic [3:0]  i_wstrb, d_wstrb;
  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
  logic [31:0] i_rdata, d_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;
  logic        err_orphan;

  int n_checks = 0;
  int n_fail   = 0;
  bit q_src[$];

  always #5 clk = ~clk;

  sram_port_arbiter #(.OUTST_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_addr_ok(i_addr_ok),
    .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_addr_ok(d_addr_ok),
    .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_addr_ok(m_addr_ok),
    .m_data_ok(m_data_ok), .m_rdata(m_rdata), .err_orphan(err_orphan)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1'b1;
    i_req = 0; i_wr = 0; i_size = 2'd2; i_addr = 0; i_wdata = 32'h11110000; i_wstrb = 4'h0;
    d_req = 0; d_wr = 0; d_size = 2'd2; d_addr = 32'h80000000; d_wdata = 32'h22220000; d_wstrb = 4'h0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    step(); step();
    rst = 1'b0;
    settle();
    check("rst_m_req", m_req, 0);
    check("rst_i_addr_ok", i_addr_ok, 0);
    check("rst_d_addr_ok", d_addr_ok, 0);
    check("rst_i_data_ok", i_data_ok, 0);
    check("rst_err_orphan", err_orphan, 0);
    check("rst_m_addr_from_d", m_addr, 32'h80000000);

    // 1: lone inst read, response two cycles after accept
    step();
    i_req = 1; i_addr = 32'h1C000000; m_addr_ok = 1;
    settle();
    check("t1_m_req", m_req, 1);
    check("t1_m_addr", m_addr, 32'h1C000000);
    check("t1_i_addr_ok", i_addr_ok, 1);
    check("t1_d_addr_ok", d_addr_ok, 0);
    step();
    i_req = 0; m_addr_ok = 0;
    settle();
    check("t1_idle_m_req", m_req, 0);
    step();
    m_data_ok = 1; m_rdata = 32'h12345678;
    settle();
    check("t1_i_data_ok", i_data_ok, 1);
    check("t1_i_rdata", i_rdata, 32'h12345678);
    check("t1_d_data_ok", d_data_ok, 0);
    check("t1_d_rdata", d_rdata, 0);
    step();
    m_data_ok = 0;

    // 2: simultaneous requests, data first
    i_req = 1; i_addr = 32'h1C000100; d_req = 1; d_addr = 32'h80001000; m_addr_ok = 1;
    settle();
    check("t2_d_first", {i_addr_ok, d_addr_ok}, 2'b01);
    check("t2_m_addr_d", m_addr, 32'h80001000);
    step();
    d_req = 0;
    settle();
    check("t2_i_second", {i_addr_ok, d_addr_ok}, 2'b10);
    check("t2_m_addr_i", m_addr, 32'h1C000100);
    step();
    i_req = 0; m_data_ok = 1; m_rdata = 32'hAAAA0000;
    settle();
    check("t2_rsp_d", {i_data_ok, d_data_ok}, 2'b01);
    check("t2_d_rdata", d_rdata, 32'hAAAA0000);
    check("t2_i_rdata0", i_rdata, 0);
    step();
    m_rdata = 32'h5555FFFF;
    settle();
    check("t2_rsp_i", {i_data_ok, d_data_ok}, 2'b10);
    check("t2_i_rdata", i_rdata, 32'h5555FFFF);
    step();
    m_data_ok = 0;

    // 3: starvation forces inst on the 9th grant, then data wins again
    i_req = 1; d_req = 1; m_addr_ok = 1;
    for (int g = 1; g <= 10; g++) begin
      settle();
      check($sformatf("t3_grant%0d", g), {i_addr_ok, d_addr_ok}, (g == 9) ? 2'b10 : 2'b01);
      if (g >= 2) check($sformatf("t3_i_rsp%0d", g), i_data_ok, (g == 10) ? 1 : 0);
      step();
      m_data_ok = 1;
    end
    i_req = 0; d_req = 0;
    settle();
    check("t3_last_rsp_d", d_data_ok, 1);
    check("t3_idle", m_req, 0);
    step();
    m_data_ok = 0;

    // 4: inst held off by a stalled downstream; data waits for the inst accept
    i_req = 1; i_addr = 32'h1C000200; m_addr_ok = 0;
    settle();
    check("t4_m_req", m_req, 1);
    check("t4_i_addr_ok0", i_addr_ok, 0);
    step();
    d_req = 1; d_addr = 32'h80002000;
    for (int c = 2; c <= 5; c++) begin
      settle();
      check($sformatf("t4_hold_addr%0d", c), m_addr, 32'h1C000200);
      check($sformatf("t4_hold_d%0d", c), d_addr_ok, 0);
      step();
    end
    m_addr_ok = 1;
    settle();
    check("t4_i_accept", {i_addr_ok, d_addr_ok}, 2'b10);
    check("t4_accept_addr", m_addr, 32'h1C000200);
    step();
    i_req = 0;
    settle();
    check("t4_d_accept", {i_addr_ok, d_addr_ok}, 2'b01);
    check("t4_d_addr", m_addr, 32'h80002000);
    step();
    d_req = 0; m_data_ok = 1; m_rdata = 32'h0000_0044;
    settle();
    check("t4_rsp_i", {i_data_ok, d_data_ok}, 2'b10);
    step();
    settle();
    check("t4_rsp_d", {i_data_ok, d_data_ok}, 2'b01);
    step();
    m_data_ok = 0;

    // 5: fill the FIFO with writes, block, resume, then wrap
    d_req = 1; d_wr = 1; d_wstrb = 4'hF; m_addr_ok = 1;
    for (int k = 1; k <= 4; k++) begin
      d_addr = 32'h80003000 + 32'(k * 4);
      settle();
      check($sformatf("t5_fill%0d", k), d_addr_ok, 1);
      if (k == 1) check("t5_m_wr", m_wr, 1);
      q_src.push_back(1'b1);
      step();
    end
    settle();
    check("t5_full_m_req", m_req, 0);
    check("t5_full_d_addr_ok", d_addr_ok, 0);
    step();
    m_data_ok = 1;
    settle();
    check("t5_pop_blocks", d_addr_ok, 0);
    check("t5_pop_d_data_ok", d_data_ok, 1);
    void'(q_src.pop_front());
    step();
    m_data_ok = 0;
    settle();
    check("t5_resume", d_addr_ok, 1);
    q_src.push_back(1'b1);
    step();
    for (int k = 8; k <= 18; k++) begin
      bit odd, acc, head;
      odd = (k % 2) == 1;
      acc = (k >= 9) && (k <= 15);
      i_req = (k <= 15) && odd;
      d_req = (k <= 15) && !odd;
      m_data_ok = 1; m_rdata = 32'(k);
      settle();
      head = q_src.pop_front();
      check($sformatf("t5_acc%0d", k), {i_addr_ok, d_addr_ok}, acc ? (odd ? 2'b10 : 2'b01) : 2'b00);
      check($sformatf("t5_rsp%0d", k), {i_data_ok, d_data_ok}, head ? 2'b01 : 2'b10);
      if (acc) q_src.push_back(!odd);
      step();
    end
    i_req = 0; d_req = 0; d_wr = 0; m_data_ok = 0;
    settle();
    check("t5_drained_idle", m_req, 0);

    // 6: orphan response, then async reset during a data hold
    step();
    m_data_ok = 1;
    settle();
    check("t6_orphan_rsp", {i_data_ok, d_data_ok}, 2'b00);
    step();
    m_data_ok = 0;
    settle();
    check("t6_err_orphan", err_orphan, 1);
    d_req = 1; d_addr = 32'h80004000; m_addr_ok = 0;
    settle();
    check("t6_grant_d", m_req, 1);
    step();
    settle();
    check("t6_hold_d", m_req, 1);
    rst = 1;
    #1;
    check("t6_rst_m_req", m_req, 0);
    check("t6_rst_err", err_orphan, 0);
    d_req = 0;
    step();
    rst = 0;
    m_data_ok = 1;
    settle();
    check("t6_post_rst_empty", d_data_ok, 0);
    step();
    m_data_ok = 0;
    settle();
    check("t6_post_rst_orphan", err_orphan, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
